// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimation controller.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  localparam int FIFO_DEPTH = 2;

  function automatic int unsigned clamp_rate(input int unsigned cfg, input int unsigned max_log2);
    return (cfg > max_log2) ? max_log2 : cfg;
  endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// Two-entry first-word-fall-through output FIFO; the head is presented directly on out_data.
module cic_out_fifo
  import cic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign pop = out_ready && (count_q != 2'd0);

  // A push into a full FIFO without a pop cannot occur: the controller's credit check prevents it.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (count_q == 2'd0) begin
      if (push) begin
        head_d  = push_data;
        count_d = 2'd1;
      end
    end else if (count_q == 2'd1) begin
      if (push && pop) begin
        head_d = push_data;
      end else if (push) begin
        tail_d  = push_data;
        count_d = 2'd2;
      end else if (pop) begin
        count_d = 2'd0;
      end
    end else if (count_q == FULL) begin
      if (pop) begin
        head_d = tail_q;
        if (push) tail_d = push_data;
        else      count_d = 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for the CIC decimator: input handshake, datapath strobes,
// start-up discard, in-flight result tracking and credit-based output backpressure.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STAGES        = 1,
  parameter int MAX_RATE_LOG2 = 4,
  parameter int PIPE_LAT      = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               stop,
  input  logic [$clog2(MAX_RATE_LOG2+1)-1:0] cfg_rate_log2,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               dp_ce,
  output logic                               dp_dec,
  output logic                               dp_clr,
  input  logic [WIDTH-1:0]                   dp_out,
  output logic                               out_valid,
  output logic [WIDTH-1:0]                   out_data,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         dbg_state
);

  localparam int CW = $clog2(MAX_RATE_LOG2 + 1);
  localparam int PW = (MAX_RATE_LOG2 > 0) ? MAX_RATE_LOG2 : 1;
  localparam int WW = (STAGES > 1) ? $clog2(STAGES + 1) : 1;

  ctrl_state_t       state_q, state_d;
  logic [CW-1:0]     rate_q, rate_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [WW-1:0]     warm_q, warm_d;
  logic              clr_q, clr_d;
  logic              done_q, done_d;
  logic [PIPE_LAT-1:0] dl_v_q, dl_v_d, dl_disc_q, dl_disc_d;

  logic [PW-1:0] rmask;
  logic          phase_last, accept, fifo_push;
  logic [7:0]    kept;
  logic [1:0]    fifo_count;

  assign rmask      = PW'((32'd1 << rate_q) - 32'd1);
  assign phase_last = (phase_q == rmask);

  // Results already committed to the consumer: queued in the FIFO or in flight and not discarded.
  always_comb begin
    kept = 8'(fifo_count);
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (dl_v_q[i] && !dl_disc_q[i]) kept = kept + 8'd1;
    end
  end

  assign in_ready  = ((state_q == WARM) || (state_q == RUN)) && !clr_q &&
                     !(phase_last && (state_q == RUN) && (kept >= 8'd2));
  assign accept    = in_valid && in_ready;
  assign dp_ce     = accept;
  assign dp_dec    = accept && phase_last;
  assign fifo_push = dl_v_q[PIPE_LAT-1] && !dl_disc_q[PIPE_LAT-1];

  always_comb begin
    state_d      = state_q;
    rate_d       = rate_q;
    phase_d      = phase_q;
    warm_d       = warm_q;
    clr_d        = 1'b0;
    done_d       = 1'b0;
    dl_v_d[0]    = dp_dec;
    dl_disc_d[0] = (state_q == WARM);
    for (int i = 1; i < PIPE_LAT; i++) begin
      dl_v_d[i]    = dl_v_q[i-1];
      dl_disc_d[i] = dl_disc_q[i-1];
    end
    if (accept) phase_d = phase_last ? '0 : phase_q + PW'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d = WARM;
        rate_d  = CW'(clamp_rate(32'(cfg_rate_log2), MAX_RATE_LOG2));
        phase_d = '0;
        warm_d  = '0;
        clr_d   = 1'b1;
      end
      WARM: if (stop) begin
        state_d = DRAIN;
        phase_d = '0;
      end else if (dp_dec) begin
        warm_d = warm_q + WW'(1);
        if (warm_q == WW'(STAGES - 1)) state_d = RUN;
      end
      RUN: if (stop) begin
        state_d = DRAIN;
        phase_d = '0;
      end
      DRAIN: if ((dl_v_q == '0) && (fifo_count == 2'd0)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rate_q    <= '0;
      phase_q   <= '0;
      warm_q    <= '0;
      clr_q     <= 1'b1;
      done_q    <= 1'b0;
      dl_v_q    <= '0;
      dl_disc_q <= '0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      phase_q   <= phase_d;
      warm_q    <= warm_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      dl_v_q    <= dl_v_d;
      dl_disc_q <= dl_disc_d;
    end
  end

  cic_out_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (dp_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (fifo_count)
  );

  assign dp_clr    = clr_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl; the datapath result is a known function of the cycle number.
module tb_cic_decim_ctrl;
  import cic_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, stop = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] cfg_rate_log2 = 3'd0;
  logic in_ready, dp_ce, dp_dec, dp_clr, out_valid, busy, done;
  logic [WIDTH-1:0] dp_out, out_data;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [WIDTH-1:0] exp_q[$];

  cic_decim_ctrl #(.WIDTH(WIDTH), .STAGES(1), .MAX_RATE_LOG2(4), .PIPE_LAT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_rate_log2(cfg_rate_log2),
    .in_valid(in_valid), .in_ready(in_ready), .dp_ce(dp_ce), .dp_dec(dp_dec),
    .dp_clr(dp_clr), .dp_out(dp_out), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign dp_out = 8'(cyc) ^ 8'hA5;

  function automatic logic [WIDTH-1:0] dp_at(input int c);
    return 8'(c) ^ 8'hA5;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_start(input logic [2:0] cfg);
    step(); start = 1'b1; cfg_rate_log2 = cfg; settle();
    step(); start = 1'b0; settle();
  endtask

  task automatic finish_run();
    bit seen;
    seen = 1'b0;
    step(); in_valid = 1'b0; stop = 1'b1; out_ready = 1'b1; settle();
    step(); stop = 1'b0; settle();
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else begin step(); settle(); end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL drain_done_timeout done never pulsed"); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step(); settle();
    checks++;
    if ({in_ready, dp_ce, dp_dec, dp_clr, out_valid, busy, done} !== 7'b0001000) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0001000", {in_ready, dp_ce, dp_dec, dp_clr, out_valid, busy, done});
    end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    step(); rst = 1'b0; settle();
    step(); settle();
    checks++;
    if (dp_clr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset dp_clr=%b busy=%b exp 0 0", dp_clr, busy);
    end
  endtask

  task automatic test_warmup();
    int a8, a12, outs;
    bit exp_v;
    a8 = 0; a12 = 0; outs = 0;
    out_ready = 1'b1;
    do_start(3'd2);
    checks++;
    if (dp_clr !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL warm_clr dp_clr=%b in_ready=%b exp 1 0", dp_clr, in_ready);
    end
    for (int k = 0; k < 12; k++) begin
      step(); in_valid = 1'b1; settle();
      if (k == 7) a8 = cyc;
      if (k == 11) a12 = cyc;
      checks++;
      if (dp_ce !== 1'b1 || dp_dec !== (k % 4 == 3) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL warm_accept k=%0d ce=%b dec=%b ov=%b exp 1 %b 0", k, dp_ce, dp_dec, out_valid, (k % 4 == 3));
      end
    end
    for (int k = 0; k < 16; k++) begin
      step(); in_valid = 1'b0; settle();
      exp_v = (cyc == a8 + 6) || (cyc == a12 + 6);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL warm_out_valid cyc=%0d got %b exp %b", cyc, out_valid, exp_v);
      end
      if (exp_v) begin
        outs++;
        checks++;
        if (out_data !== dp_at(cyc - 1)) begin
          errors++; $display("FAIL warm_out_data got %h exp %h", out_data, dp_at(cyc - 1));
        end
      end
    end
    checks++;
    if (outs != 2) begin errors++; $display("FAIL warm_out_count got %0d exp 2", outs); end
    checks++;
    if (dbg_state !== RUN) begin errors++; $display("FAIL warm_to_run got %0d exp %0d", dbg_state, RUN); end
    finish_run();
  endtask

  task automatic test_backpressure();
    int a8, a12;
    logic [WIDTH-1:0] exp;
    a8 = 0; a12 = 0;
    out_ready = 1'b0;
    do_start(3'd2);
    for (int k = 0; k < 40; k++) begin
      step(); in_valid = 1'b1; settle();
      if (k == 7) a8 = cyc;
      if (k == 11) a12 = cyc;
      checks++;
      if (dp_ce !== (k < 15)) begin
        errors++; $display("FAIL bp_accept k=%0d got %b exp %b", k, dp_ce, (k < 15));
      end
    end
    exp_q.push_back(dp_at(a8 + 5));
    exp_q.push_back(dp_at(a12 + 5));
    step(); out_ready = 1'b1; settle();
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_pop1 ov=%b data=%h ir=%b exp 1 %h 0", out_valid, out_data, in_ready, exp);
    end
    step(); settle();
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      errors++; $display("FAIL bp_pop2 ov=%b data=%h exp 1 %h", out_valid, out_data, exp);
    end
    checks++;
    if (in_ready !== 1'b1 || dp_dec !== 1'b1) begin
      errors++; $display("FAIL bp_resume ir=%b dec=%b exp 1 1", in_ready, dp_dec);
    end
    finish_run();
  endtask

  task automatic test_rate_corners();
    out_ready = 1'b1;
    do_start(3'd0);
    for (int k = 0; k < 4; k++) begin
      step(); in_valid = 1'b1; settle();
      checks++;
      if (dp_ce !== (k < 3) || dp_dec !== (k < 3)) begin
        errors++; $display("FAIL rate1 k=%0d ce=%b dec=%b exp %b %b", k, dp_ce, dp_dec, (k < 3), (k < 3));
      end
    end
    finish_run();
    do_start(3'd7);
    for (int k = 0; k < 32; k++) begin
      step(); in_valid = 1'b1; settle();
      checks++;
      if (dp_ce !== 1'b1 || dp_dec !== (k % 16 == 15)) begin
        errors++; $display("FAIL rate16 k=%0d ce=%b dec=%b exp 1 %b", k, dp_ce, dp_dec, (k % 16 == 15));
      end
    end
    finish_run();
  endtask

  task automatic test_stop_drain();
    int a8;
    a8 = 0;
    out_ready = 1'b0;
    do_start(3'd2);
    for (int k = 0; k < 10; k++) begin
      step(); in_valid = 1'b1; stop = (k == 9); settle();
      if (k == 7) a8 = cyc;
    end
    step(); stop = 1'b0; settle();
    checks++;
    if (in_ready !== 1'b0 || dbg_state !== DRAIN || busy !== 1'b1) begin
      errors++; $display("FAIL stop_enter ir=%b st=%0d busy=%b exp 0 3 1", in_ready, dbg_state, busy);
    end
    for (int k = 0; k < 3; k++) begin
      step(); in_valid = 1'b0; settle();
      checks++;
      if (out_valid !== (k == 2) || done !== 1'b0) begin
        errors++; $display("FAIL stop_wait k=%0d ov=%b done=%b exp %b 0", k, out_valid, done, (k == 2));
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== dp_at(a8 + 5) || done !== 1'b0) begin
        errors++; $display("FAIL stop_hold k=%0d ov=%b data=%h exp 1 %h", k, out_valid, out_data, dp_at(a8 + 5));
      end
      step(); settle();
    end
    out_ready = 1'b1;
    step(); out_ready = 1'b0; settle();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL stop_popped ov=%b done=%b exp 0 0", out_valid, done);
    end
    step(); settle();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_done done=%b busy=%b exp 1 0", done, busy);
    end
    step(); settle();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL stop_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_reset_mid_run();
    int a1;
    a1 = 0;
    out_ready = 1'b0;
    do_start(3'd0);
    for (int k = 0; k < 20; k++) begin step(); in_valid = 1'b1; settle(); end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_full ov=%b ir=%b exp 1 0", out_valid, in_ready);
    end
    step(); rst = 1'b1; settle();
    step(); rst = 1'b0; settle();
    checks++;
    if ({out_valid, in_ready, busy, dp_clr} !== 4'b0001 || out_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_clear got %b %h exp 0001 00", {out_valid, in_ready, busy, dp_clr}, out_data);
    end
    out_ready = 1'b1;
    do_start(3'd0);
    for (int k = 0; k < 9; k++) begin
      step(); settle();
      if (k == 0) a1 = cyc;
      checks++;
      if (out_valid !== (k >= 7)) begin
        errors++; $display("FAIL rstmid_warm k=%0d ov=%b exp %b", k, out_valid, (k >= 7));
      end
      if (k >= 7) begin
        checks++;
        if (out_data !== dp_at(a1 + k - 1)) begin
          errors++; $display("FAIL rstmid_data k=%0d got %h exp %h", k, out_data, dp_at(a1 + k - 1));
        end
      end
    end
    finish_run();
  endtask

  task automatic test_ignored();
    out_ready = 1'b1;
    do_start(3'd2);
    for (int k = 0; k < 4; k++) begin step(); in_valid = 1'b1; settle(); end
    step(); in_valid = 1'b0; start = 1'b1; cfg_rate_log2 = 3'd0; settle();
    step(); start = 1'b0; settle();
    checks++;
    if (dp_clr !== 1'b0 || dbg_state !== RUN) begin
      errors++; $display("FAIL start_in_run clr=%b st=%0d exp 0 %0d", dp_clr, dbg_state, RUN);
    end
    for (int k = 0; k < 4; k++) begin
      step(); in_valid = 1'b1; settle();
      checks++;
      if (dp_dec !== (k == 3)) begin errors++; $display("FAIL rate_kept k=%0d got %b exp %b", k, dp_dec, (k == 3)); end
    end
    finish_run();
    step(); stop = 1'b1; settle();
    for (int k = 0; k < 5; k++) begin
      step(); stop = 1'b0; settle();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL stop_in_idle k=%0d busy=%b done=%b exp 0 0", k, busy, done);
      end
    end
    step(); start = 1'b1; stop = 1'b1; cfg_rate_log2 = 3'd2; settle();
    step(); start = 1'b0; stop = 1'b0; settle();
    checks++;
    if (dbg_state !== WARM || dp_clr !== 1'b1) begin
      errors++; $display("FAIL start_stop_same st=%0d clr=%b exp %0d 1", dbg_state, dp_clr, WARM);
    end
    finish_run();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_warmup();
    test_backpressure();
    test_rate_corners();
    test_stop_drain();
    test_reset_mid_run();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
